// File: rtl/scene_cache_pkg.sv
// Shared types and widths for the scene cache: sphere record, FSM states.
package scene_cache_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CNT_W   = 8;

    typedef struct packed {
        logic signed [COORD_W-1:0] cx;
        logic signed [COORD_W-1:0] cy;
        logic signed [COORD_W-1:0] cz;
        logic signed [COORD_W-1:0] radius;
        logic        [COLOR_W-1:0] color_r;
        logic        [COLOR_W-1:0] color_g;
        logic        [COLOR_W-1:0] color_b;
        logic signed [COORD_W-1:0] reflectivity;
    } sphere_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/scene_cache_mem.sv
// Sphere entry array: one write port, one registered read port (read-before-write).
module scene_cache_mem
    import scene_cache_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  sphere_t                  wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output sphere_t                  rd_data_o
);

    sphere_t mem_q [DEPTH];
    sphere_t rd_data_q;

    // Entry storage: deliberately not reset, stale data is masked by rd_valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: samples the old contents on a same-entry write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/scene_cache.sv
// Scene cache: requests a sphere stream, stores it, and serves indexed reads.
module scene_cache
    import scene_cache_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_req,
    output logic                      start,
    input  logic                      valid,
    output logic                      ready,
    input  logic [7:0]                idx,
    input  logic                      last,
    input  logic                      done,
    input  logic signed [11:0]        cx,
    input  logic signed [11:0]        cy,
    input  logic signed [11:0]        cz,
    input  logic signed [11:0]        radius,
    input  logic [7:0]                colorR,
    input  logic [7:0]                colorG,
    input  logic [7:0]                colorB,
    input  logic signed [11:0]        reflectivity,
    output logic                      loaded,
    output logic                      busy,
    output logic [7:0]                count,
    output logic                      err_seq,
    output logic                      err_ovf,
    output logic                      err_tmo,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic                      rd_valid,
    output logic signed [11:0]        rd_cx,
    output logic signed [11:0]        rd_cy,
    output logic signed [11:0]        rd_cz,
    output logic signed [11:0]        rd_radius,
    output logic [7:0]                rd_colorR,
    output logic [7:0]                rd_colorG,
    output logic [7:0]                rd_colorB,
    output logic signed [11:0]        rd_reflectivity
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               loaded_q, loaded_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_seq_q, err_seq_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_tmo_q, err_tmo_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               rd_valid_q, rd_valid_d;
    logic               we_c;
    sphere_t            wr_rec_c;
    sphere_t            rd_rec;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
            count_q    <= '0;
            err_seq_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            tmo_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            loaded_q   <= loaded_d;
            count_q    <= count_d;
            err_seq_q  <= err_seq_d;
            err_ovf_q  <= err_ovf_d;
            err_tmo_q  <= err_tmo_d;
            tmo_q      <= tmo_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state, bookkeeping and write-enable decode.
    always_comb begin
        state_d    = state_q;
        loaded_d   = loaded_q;
        count_d    = count_q;
        err_seq_d  = err_seq_q;
        err_ovf_d  = err_ovf_q;
        err_tmo_d  = err_tmo_q;
        tmo_d      = tmo_q;
        we_c       = 1'b0;
        start_d    = 1'b0;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        rd_valid_d = loaded_q && (CNT_W'(rd_addr) < count_q);

        unique case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d   = ST_REQ;
                    loaded_d  = 1'b0;
                    count_d   = '0;
                    err_seq_d = 1'b0;
                    err_ovf_d = 1'b0;
                    err_tmo_d = 1'b0;
                    tmo_d     = '0;
                end
            end
            ST_REQ: begin
                state_d = ST_RECV;
            end
            ST_RECV: begin
                if (valid) begin
                    tmo_d = '0;
                    if (count_q < CNT_W'(DEPTH)) begin
                        we_c = 1'b1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                    if (idx != count_q) begin
                        err_seq_d = 1'b1;
                    end
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (last || done) begin
                    state_d = ST_FIN;
                end else if (!valid && (tmo_q + TW'(1) == TW'(TIMEOUT))) begin
                    err_tmo_d = 1'b1;
                    loaded_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_FIN: begin
                if (!err_tmo_q) begin
                    loaded_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        start_d = (state_d == ST_REQ);
        ready_d = (state_d == ST_RECV);
        busy_d  = start_d || ready_d;
    end

    // Pack the incoming record for the array.
    always_comb begin
        wr_rec_c              = '0;
        wr_rec_c.cx           = cx;
        wr_rec_c.cy           = cy;
        wr_rec_c.cz           = cz;
        wr_rec_c.radius       = radius;
        wr_rec_c.color_r      = colorR;
        wr_rec_c.color_g      = colorG;
        wr_rec_c.color_b      = colorB;
        wr_rec_c.reflectivity = reflectivity;
    end

    scene_cache_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (we_c),
        .wr_addr_i (idx[AW-1:0]),
        .wr_data_i (wr_rec_c),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_rec)
    );

    assign start           = start_q;
    assign ready           = ready_q;
    assign busy            = busy_q;
    assign loaded          = loaded_q;
    assign count           = count_q;
    assign err_seq         = err_seq_q;
    assign err_ovf         = err_ovf_q;
    assign err_tmo         = err_tmo_q;
    assign rd_valid        = rd_valid_q;
    assign rd_cx           = rd_rec.cx;
    assign rd_cy           = rd_rec.cy;
    assign rd_cz           = rd_rec.cz;
    assign rd_radius       = rd_rec.radius;
    assign rd_colorR       = rd_rec.color_r;
    assign rd_colorG       = rd_rec.color_g;
    assign rd_colorB       = rd_rec.color_b;
    assign rd_reflectivity = rd_rec.reflectivity;

endmodule

// File: doc/scene_cache.md
SCENE_CACHE -- requirements
Module: scene_cache

Interface
REQ-001 Parameter DEPTH, default 8, sets the number of sphere entries stored (power of two, 2..64).
REQ-002 Parameter TIMEOUT, default 255, sets the idle-stream cycles allowed in RECV before abort.
REQ-003 Ports, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  request scene (re)load; sampled in IDLE only
- start  out  1  one-cycle pulse to the scene stream source
- valid  in  1  stream record present
- ready  out  1  cache accepts record
- idx  in  8  stream record index
- last  in  1  final record marker
- done  in  1  stream finished
- cx, cy, cz, radius  in  12 each, signed  sphere geometry
- colorR, colorG, colorB  in  8 each  sphere colour
- reflectivity  in  12, signed  sphere reflectivity
- loaded  out  1  cache holds a complete scene
- busy  out  1  load in progress
- count  out  8  entries accepted in the current/last load
- err_seq  out  1  sticky: idx differed from expected
- err_ovf  out  1  sticky: record received with count==DEPTH
- err_tmo  out  1  sticky: stream timed out
- rd_addr  in  log2(DEPTH)  read index
- rd_valid  out  1  rd_data valid and rd_addr was < count
- rd_cx, rd_cy, rd_cz, rd_radius, rd_colorR, rd_colorG, rd_colorB, rd_reflectivity  out  as inputs  read data

Function
REQ-004 FSM states IDLE, REQ, RECV, FIN; a record is accepted on any cycle with valid && ready.
REQ-005 IDLE: ready=0, busy=0; load_req=1 -> REQ, clearing loaded, count, err_seq, err_ovf, err_tmo and the timeout counter.
REQ-006 REQ: start=1 for exactly this cycle, busy=1; unconditional -> RECV.
REQ-007 RECV: ready=1, busy=1; each accepted record is written at entry idx[log2(DEPTH)-1:0] when count<DEPTH, and count increments, saturating at 255.
REQ-008 Accepted record with idx != count sets err_seq; the record is still written.
REQ-009 Accepted record with count==DEPTH is dropped, sets err_ovf, and ready stays 1 so the source never stalls.
REQ-010 In RECV, last or done -> FIN; a record accepted in the same cycle as last is stored first.
REQ-011 Timeout counter increments each RECV cycle without valid and clears on valid; reaching TIMEOUT sets err_tmo and -> IDLE with loaded=0.
REQ-012 FIN: loaded<=1 unless err_tmo is set, busy=0; -> IDLE next cycle.
REQ-013 load_req outside IDLE is ignored; valid, last and done outside RECV are ignored.
REQ-014 Read port: one-cycle registered latency; rd_valid=loaded && (rd_addr<count) sampled with rd_addr; rd_* hold the entry contents whatever rd_valid is.
REQ-015 A read and a write to the same entry in the same cycle return the old contents.
REQ-016 Entry storage is not reset; stale contents are masked only by rd_valid.

Reset
REQ-017 rst_n low asynchronously forces IDLE, start=0, ready=0, busy=0, loaded=0, count=0, all err_* = 0, rd_valid=0 and timeout counter 0; rd_* data are 0.
REQ-018 Reset asserted mid-RECV abandons the load; after release, the block waits for a new load_req.

Structure
REQ-019 The shared package holds the sphere record struct (cx, cy, cz, radius, colour triplet, reflectivity), the FSM state enum and the field-width constants (COORD_W=12, COLOR_W=8).
REQ-020 One sub-module, scene_cache_mem: a DEPTH-entry, single-write, single-registered-read array of the sphere struct.

Verification
REQ-021 Reset, then load_req pulse -> start high exactly 1 cycle, 1 cycle later; ready high the following cycle.
REQ-022 Stream of 3 records with idx 0,1,2, last on idx 2 -> count=3, loaded=1, no err_*; rd_addr=1 returns record 1 one cycle later with rd_valid=1; rd_addr=3 -> rd_valid=0.
REQ-023 Records with idx 0,2 then done -> err_seq=1, count=2, loaded=1.
REQ-024 DEPTH=8, 10 records with last on the 10th -> err_ovf=1, count=10, entries 0..7 intact, loaded=1.
REQ-025 start answered by 255 cycles without valid -> err_tmo=1, state IDLE, loaded=0; a new load_req clears err_tmo.
REQ-026 rst_n dropped after 2 of 5 records -> all outputs are at reset values immediately; a later full load of 5 records gives count=5, loaded=1.
